trigger_process_multi: RTL

Multi-channel, parametrised trigger conditioner for the sTGC TDS data-logging path. Each channel synchronises an already-buffered single-ended trigger input and detects its rising edge. On an edge it emits a fixed-width gate pulse and advances a per-channel trigger index. The channel then re-arms only after two `cycle_tick` strobes. It sits between the top-level differential input buffers and the capture/readout logic.

---
 rtl/trigger_process_multi_if.sv | 30 +++
 rtl/trigger_process_multi.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/trigger_process_multi_if.sv
// Signal bundle for trigger_process_multi: raw triggers and controls in,
// per-channel gates, indices and miss counters out.
interface trigger_process_multi_if #(
    parameter int N_CH    = 4,
    parameter int WIDTH_W = 10,
    parameter int INDEX_W = 8,
    parameter int MISS_W  = 16
);
    logic [N_CH-1:0]         trigger_in;
    logic                    enable_trigger;
    logic [N_CH-1:0]         ch_mask;
    logic                    retrigger_en;
    logic [WIDTH_W-1:0]      trigger_width;
    logic                    cycle_tick;
    logic [N_CH-1:0]         trigger;
    logic                    trigger_any;
    logic [N_CH*INDEX_W-1:0] trigger_index;
    logic [N_CH*MISS_W-1:0]  missed_count;
    logic [N_CH-1:0]         debug_enable;

    modport master (
        output trigger_in, enable_trigger, ch_mask, retrigger_en, trigger_width, cycle_tick,
        input  trigger, trigger_any, trigger_index, missed_count, debug_enable
    );

    modport slave (
        input  trigger_in, enable_trigger, ch_mask, retrigger_en, trigger_width, cycle_tick,
        output trigger, trigger_any, trigger_index, missed_count, debug_enable
    );
endinterface

// File: rtl/trigger_process_multi.sv
// Multi-channel trigger conditioner: synchronise, edge-detect, gate pulse, index, two-tick re-arm.
// Optional missed-edge counters are built only when TRIG_MISS_CNT_EN is defined.
module trigger_process_multi #(
    parameter int N_CH        = 4,
    parameter int WIDTH_W     = 10,
    parameter int INDEX_W     = 8,
    parameter int SYNC_STAGES = 2,
    parameter int MISS_W      = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    trigger_process_multi_if.slave bus
);
    typedef enum logic [1:0] {
        ARMED = 2'd0,
        WAIT1 = 2'd1,
        WAIT2 = 2'd2
    } state_e;

    logic [N_CH-1:0]    sync_q [SYNC_STAGES];
    logic [N_CH-1:0]    prev_q;
    logic [N_CH-1:0]    rise;
    logic [N_CH-1:0]    busy;
    logic [N_CH-1:0]    start;
    logic [N_CH-1:0]    gate;
    logic [N_CH-1:0]    dbg;

    state_e             state_q [N_CH];
    state_e             state_d [N_CH];
    logic [WIDTH_W-1:0] count_q [N_CH];
    logic [WIDTH_W-1:0] count_d [N_CH];
    logic [INDEX_W-1:0] index_q [N_CH];
    logic [INDEX_W-1:0] index_d [N_CH];

    // NOTE: sequential blocks use non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
            prev_q <= '0;
        end else begin
            sync_q[0] <= bus.trigger_in;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

    always_comb begin
        busy  = '0;
        start = '0;
        for (int c = 0; c < N_CH; c++) begin
            busy[c]  = (count_q[c] != '0);
            start[c] = rise[c] & bus.ch_mask[c] &
                       ((state_q[c] == ARMED) | (bus.retrigger_en & busy[c]));
        end
    end

    // NOTE: every next-state variable takes its default before any branch, so no path can infer a latch.
    always_comb begin
        for (int c = 0; c < N_CH; c++) begin
            state_d[c] = state_q[c];
            count_d[c] = count_q[c];
            index_d[c] = index_q[c];
            if (start[c]) begin
                // A start wins over a coincident tick, so the two-tick re-arm restarts from here.
                state_d[c] = WAIT1;
                count_d[c] = bus.trigger_width;
                index_d[c] = index_q[c] + INDEX_W'(1);
            end else begin
                if (busy[c]) begin
                    count_d[c] = count_q[c] - WIDTH_W'(1);
                end
                if (bus.cycle_tick) begin
                    case (state_q[c])
                        WAIT1:   state_d[c] = WAIT2;
                        WAIT2:   state_d[c] = ARMED;
                        default: state_d[c] = state_q[c];
                    endcase
                end
            end
        end
    end

    // NOTE: these per-channel arrays are a handful of flops and are reset like any register, unlike a bulk RAM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < N_CH; c++) begin
                state_q[c] <= ARMED;
                count_q[c] <= '0;
                index_q[c] <= '0;
            end
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                state_q[c] <= state_d[c];
                count_q[c] <= count_d[c];
                index_q[c] <= index_d[c];
            end
        end
    end

    // Bypass forces every gate and debug bit high; otherwise both come straight from registers.
    always_comb begin
        gate = '1;
        dbg  = '1;
        if (bus.enable_trigger) begin
            for (int c = 0; c < N_CH; c++) begin
                gate[c] = busy[c];
                dbg[c]  = (state_q[c] == WAIT2);
            end
        end
    end

    assign bus.trigger      = gate;
    assign bus.debug_enable = dbg;
    assign bus.trigger_any  = |gate;

    for (genvar c = 0; c < N_CH; c++) begin : g_index
        assign bus.trigger_index[c*INDEX_W +: INDEX_W] = index_q[c];
    end

`ifdef TRIG_MISS_CNT_EN
    logic [N_CH-1:0]   miss_evt;
    logic [MISS_W-1:0] miss_q [N_CH];

    assign miss_evt = rise & bus.ch_mask & ~start;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < N_CH; c++) begin
                miss_q[c] <= '0;
            end
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                if (miss_evt[c] && (miss_q[c] != '1)) begin
                    miss_q[c] <= miss_q[c] + MISS_W'(1);
                end
            end
        end
    end

    for (genvar c = 0; c < N_CH; c++) begin : g_miss
        assign bus.missed_count[c*MISS_W +: MISS_W] = miss_q[c];
    end
`else
    assign bus.missed_count = '0;
`endif

endmodule
